// File: rtl/ctrl_seq.sv
// Instruction sequencer: fetch/decode/execute loop driving the 8-bit ALU, carry register,
// accumulator and register-file strobes from a synchronous program ROM.
module ctrl_seq #(
  parameter int unsigned PC_W   = 8,
  parameter logic [15:0] IR_RST = 16'hB000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run_i,
  input  logic [15:0]     instr_i,
  input  logic            cy_i,
  output logic [PC_W-1:0] pc_o,
  output logic [3:0]      alu_op_o,
  output logic            alu_ci_o,
  output logic            alu_b_sel_o,
  output logic [7:0]      imm_o,
  output logic [2:0]      reg_addr_o,
  output logic            acc_we_o,
  output logic            reg_we_o,
  output logic            cy_ce_o,
  output logic            halted_o
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StDecode = 3'd2;
  localparam logic [2:0] StExec   = 3'd3;
  localparam logic [2:0] StHalt   = 3'd4;

  localparam logic [3:0] OpAdd = 4'h0;
  localparam logic [3:0] OpSub = 4'h1;
  localparam logic [3:0] OpMov = 4'h6;
  localparam logic [3:0] OpSta = 4'h7;
  localparam logic [3:0] OpJmp = 4'h8;
  localparam logic [3:0] OpJc  = 4'h9;
  localparam logic [3:0] OpJnc = 4'hA;
  localparam logic [3:0] OpHlt = 4'hF;

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;

  logic [3:0]      opcode;
  logic            use_c;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] pc_inc;
  logic            unused_ir;

  assign opcode    = ir_q[15:12];
  assign use_c     = ir_q[11];
  assign target    = PC_W'(ir_q[7:0]);
  assign pc_inc    = pc_q + PC_W'(1);
  assign unused_ir = ^ir_q[9:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= IR_RST;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      StIdle:   if (run_i) state_d = StFetch;
      StFetch:  state_d = StDecode;
      StDecode: begin
        ir_d    = instr_i;
        state_d = StExec;
      end
      StExec: begin
        case (opcode)
          OpJmp:   pc_d = target;
          OpJc:    pc_d = cy_i ? target : pc_inc;
          OpJnc:   pc_d = cy_i ? pc_inc : target;
          OpHlt:   pc_d = pc_q;
          default: pc_d = pc_inc;
        endcase
        if (opcode == OpHlt) state_d = StHalt;
        else if (run_i)      state_d = StFetch;
        else                 state_d = StIdle;
      end
      StHalt:   if (!run_i) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Operand/op fields decode continuously from IR; only the strobes are gated by EXEC.
  always_comb begin
    alu_op_o = (opcode <= 4'h5) ? opcode : 4'b1111;
    alu_ci_o = ((opcode == OpAdd) || (opcode == OpSub)) ? (use_c & cy_i) : 1'b0;
    acc_we_o = 1'b0;
    reg_we_o = 1'b0;
    cy_ce_o  = 1'b0;
    if (state_q == StExec) begin
      acc_we_o = (opcode <= OpMov);
      reg_we_o = (opcode == OpSta);
      cy_ce_o  = (opcode == OpAdd);
    end
  end

  assign pc_o        = pc_q;
  assign alu_b_sel_o = ir_q[10];
  assign imm_o       = ir_q[7:0];
  assign reg_addr_o  = ir_q[2:0];
  assign halted_o    = (state_q == StHalt);

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed self-checking bench for ctrl_seq with a synchronous ROM model.
module tb_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_i;
  logic [15:0] instr_i;
  logic        cy_i;
  logic [7:0]  pc_o;
  logic [3:0]  alu_op_o;
  logic        alu_ci_o;
  logic        alu_b_sel_o;
  logic [7:0]  imm_o;
  logic [2:0]  reg_addr_o;
  logic        acc_we_o;
  logic        reg_we_o;
  logic        cy_ce_o;
  logic        halted_o;

  logic [15:0] rom [256];
  int checks = 0;
  int errors = 0;

  ctrl_seq #(.PC_W(8), .IR_RST(16'hB000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run_i       (run_i),
    .instr_i     (instr_i),
    .cy_i        (cy_i),
    .pc_o        (pc_o),
    .alu_op_o    (alu_op_o),
    .alu_ci_o    (alu_ci_o),
    .alu_b_sel_o (alu_b_sel_o),
    .imm_o       (imm_o),
    .reg_addr_o  (reg_addr_o),
    .acc_we_o    (acc_we_o),
    .reg_we_o    (reg_we_o),
    .cy_ce_o     (cy_ce_o),
    .halted_o    (halted_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) instr_i <= rom[pc_o];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'hB000;
    rom[8'h00] = 16'h0C05;  // ADD C=1 I=1 imm 5
    rom[8'h01] = 16'h1003;  // SUB reg 3
    rom[8'h02] = 16'h9040;  // JC 0x40
    rom[8'h40] = 16'h8002;  // JMP 2
    rom[8'h03] = 16'hA050;  // JNC 0x50
    rom[8'h04] = 16'hA050;  // JNC 0x50
    rom[8'h50] = 16'h80FF;  // JMP 0xFF
    rom[8'hFF] = 16'hB000;  // NOP -> wrap

    rst_n = 1'b0;
    run_i = 1'b1;
    cy_i  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc_o, 0);
    chk("rst_op", alu_op_o, 4'hF);
    chk("rst_ci", alu_ci_o, 0);
    chk("rst_bsel", alu_b_sel_o, 0);
    chk("rst_imm", imm_o, 0);
    chk("rst_raddr", reg_addr_o, 0);
    chk("rst_acc_we", acc_we_o, 0);
    chk("rst_reg_we", reg_we_o, 0);
    chk("rst_cy_ce", cy_ce_o, 0);
    chk("rst_halted", halted_o, 0);
    rst_n = 1'b1;

    // ADD at 0
    tick();
    chk("add_fetch_pc", pc_o, 0);
    chk("add_fetch_acc_we", acc_we_o, 0);
    tick();
    chk("add_decode_acc_we", acc_we_o, 0);
    tick();
    chk("add_op", alu_op_o, 4'h0);
    chk("add_ci", alu_ci_o, 1);
    chk("add_bsel", alu_b_sel_o, 1);
    chk("add_imm", imm_o, 8'h05);
    chk("add_acc_we", acc_we_o, 1);
    chk("add_cy_ce", cy_ce_o, 1);
    chk("add_reg_we", reg_we_o, 0);
    tick();
    chk("add_next_pc", pc_o, 1);
    chk("add_acc_we_drop", acc_we_o, 0);
    chk("add_cy_ce_drop", cy_ce_o, 0);

    // SUB at 1
    tick(); tick();
    chk("sub_op", alu_op_o, 4'h1);
    chk("sub_ci", alu_ci_o, 0);
    chk("sub_raddr", reg_addr_o, 3);
    chk("sub_bsel", alu_b_sel_o, 0);
    chk("sub_acc_we", acc_we_o, 1);
    chk("sub_cy_ce", cy_ce_o, 0);
    tick();
    chk("sub_next_pc", pc_o, 2);

    // JC taken
    tick(); tick();
    chk("jc_op", alu_op_o, 4'hF);
    chk("jc_acc_we", acc_we_o, 0);
    tick();
    chk("jc_taken_pc", pc_o, 8'h40);
    tick(); tick(); tick();
    chk("jmp_pc", pc_o, 8'h02);

    // JC not taken
    cy_i = 1'b0;
    tick(); tick(); tick();
    chk("jc_not_taken_pc", pc_o, 8'h03);

    // JNC not taken / taken
    cy_i = 1'b1;
    tick(); tick(); tick();
    chk("jnc_not_taken_pc", pc_o, 8'h04);
    cy_i = 1'b0;
    tick(); tick(); tick();
    chk("jnc_taken_pc", pc_o, 8'h50);
    tick(); tick(); tick();
    chk("jmp_ff_pc", pc_o, 8'hFF);

    // NOP at 0xFF wraps
    tick(); tick();
    chk("nop_acc_we", acc_we_o, 0);
    chk("nop_op", alu_op_o, 4'hF);
    tick();
    chk("wrap_pc", pc_o, 8'h00);

    // Reset during EXEC of ADD
    cy_i = 1'b1;
    tick(); tick();
    chk("add2_acc_we", acc_we_o, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_acc_we", acc_we_o, 0);
    chk("midrst_cy_ce", cy_ce_o, 0);
    chk("midrst_pc", pc_o, 0);
    chk("midrst_op", alu_op_o, 4'hF);
    chk("midrst_halted", halted_o, 0);
    rom[8'h00] = 16'h7005;  // STA reg 5
    rom[8'h01] = 16'hF000;  // HLT
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // STA at 0
    tick();
    chk("sta_fetch_pc", pc_o, 0);
    tick(); tick();
    chk("sta_reg_we", reg_we_o, 1);
    chk("sta_raddr", reg_addr_o, 5);
    chk("sta_acc_we", acc_we_o, 0);
    chk("sta_cy_ce", cy_ce_o, 0);
    tick();
    chk("sta_next_pc", pc_o, 1);
    chk("sta_reg_we_drop", reg_we_o, 0);

    // HLT at 1
    tick(); tick();
    chk("hlt_exec_halted", halted_o, 0);
    chk("hlt_exec_acc_we", acc_we_o, 0);
    tick();
    chk("hlt_halted", halted_o, 1);
    chk("hlt_pc", pc_o, 1);
    repeat (3) tick();
    chk("hlt_hold_halted", halted_o, 1);
    chk("hlt_hold_pc", pc_o, 1);
    run_i = 1'b0;
    tick();
    chk("idle_halted", halted_o, 0);
    chk("idle_pc", pc_o, 1);
    tick();
    chk("idle_stay_pc", pc_o, 1);
    chk("idle_stay_halted", halted_o, 0);
    chk("idle_reg_we", reg_we_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_seq.md
Name: ctrl_seq

Overview:
- Instruction sequencer that sits directly upstream of the 8-bit ALU and carry register.
- Fetches 16-bit instructions from a synchronous program ROM and decodes them.
- Drives the ALU op code, carry-in, operand-B source and the carry-register enable, and sequences accumulator and register-file writes and jumps.
- Fixed 3-state fetch/decode/execute loop, with run/halt control.

Parameters:
PC_W, 8, program counter width; program space is 2^PC_W words.
IR_RST, 16'hB000, instruction register reset value (a NOP encoding).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
run_i  input  1  level; 1 = execute, 0 = stop after the current instruction
instr_i  input  16  ROM read data; valid one cycle after pc_o is presented
cy_i  input  1  current carry flag from the carry register
pc_o  output  PC_W  ROM address / program counter
alu_op_o  output  4  ALU op code
alu_ci_o  output  1  ALU carry-in
alu_b_sel_o  output  1  ALU operand B source: 0 = register file, 1 = immediate
imm_o  output  8  immediate field, IR[7:0]
reg_addr_o  output  3  register-file address, IR[2:0]
acc_we_o  output  1  accumulator write strobe
reg_we_o  output  1  register-file write strobe (accumulator → reg[reg_addr_o])
cy_ce_o  output  1  carry-register enable strobe
halted_o  output  1  high in the HALT state

Behaviour:
- Instruction format: IR[15:12] = opcode, IR[11] = C (use carry), IR[10] = I (immediate B), IR[7:0] = imm or reg address.
- Opcode decode:
  - 0x0–0x5 (ADD, SUB, AND, OR, XOR, NOT): alu_op_o = opcode; acc_we_o pulses.
  - 0x6 MOV: alu_op_o = 4'b1111 (pass B); acc_we_o pulses.
  - 0x7 STA: reg_we_o pulses; acc_we_o stays 0.
  - 0x8 JMP: pc ← imm.
  - 0x9 JC: pc ← imm if cy_i = 1, else pc + 1.
  - 0xA JNC: pc ← imm if cy_i = 0, else pc + 1.
  - 0xF HLT: enter HALT.
  - 0xB–0xE: NOP.
- Carry handling:
  - alu_ci_o = C & cy_i for opcodes 0x0/0x1; 0 otherwise.
  - cy_ce_o pulses only for ADD (0x0); SUB and the logic ops leave the carry unchanged.
- Operand and op outputs:
  - alu_b_sel_o = I; imm_o and reg_addr_o are continuous decodes of IR.
  - alu_op_o is a continuous decode of IR; it is 4'b1111 for non-ALU opcodes.
- States:
  - IDLE: wait; go to FETCH when run_i = 1.
  - FETCH: pc_o is stable; ROM read is in flight.
  - DECODE: IR ← instr_i.
  - EXEC: strobes asserted for exactly this one cycle; PC updated at the end of the cycle. Next state is HALT if opcode = 0xF, else FETCH if run_i = 1, else IDLE.
  - HALT: halted_o = 1; PC frozen. Leave to IDLE only when run_i = 0; run_i held high keeps HALT.
- Timing:
  - Each instruction takes 3 cycles (FETCH, DECODE, EXEC).
  - ALU/CY/accumulator results register at the EXEC → next-state edge.
- PC rules:
  - PC increments by 1 modulo 2^PC_W; 0xFF wraps to 0x00.
  - A jump target overrides the increment.
  - HLT does not advance PC.
- Strobes: acc_we_o, reg_we_o and cy_ce_o are 0 in every state except EXEC.
- run_i dropped mid-instruction: the current instruction completes its EXEC, then the FSM goes to IDLE; PC keeps the next address.
- Reset: asynchronous and effective immediately, including mid-instruction; no partial strobe survives.
  - state = IDLE, pc_o = 0, IR = IR_RST.
  - alu_op_o = 4'b1111, alu_ci_o = 0, alu_b_sel_o = 0, imm_o = 0x00, reg_addr_o = 0.
  - acc_we_o = 0, reg_we_o = 0, cy_ce_o = 0, halted_o = 0.
- No X propagation: unknown opcodes decode as NOP.

Test Plan:
1. Reset with run_i = 1; ROM[0] = 16'h0C05 (ADD, C = 1, I = 1, imm = 5), cy_i = 1.
   - pc_o = 0 during FETCH.
   - In EXEC: alu_op_o = 0, alu_ci_o = 1, alu_b_sel_o = 1, imm_o = 0x05, acc_we_o = cy_ce_o = 1 for one cycle.
   - pc_o = 1 in the next FETCH.
2. ROM[1] = 16'h1003 (SUB, reg 3), cy_i = 1.
   - alu_ci_o = 0, reg_addr_o = 3, acc_we_o = 1, cy_ce_o = 0.
3. ROM[2] = 16'h9040 (JC 0x40):
   - cy_i = 1 → next pc_o = 0x40.
   - Rerun with cy_i = 0 → pc_o = 3.
   - JNC (16'hA040) shows the inverse result.
4. PC wrap: jump to 0xFF where ROM[0xFF] = NOP → next pc_o = 0x00.
5. ROM[n] = 16'hF000 (HLT): halted_o = 1; pc_o stays n with run_i held high; drop run_i → IDLE, halted_o = 0.
6. Assert rst_n = 0 during EXEC of an ADD → all strobes 0 immediately, pc_o = 0, FSM in IDLE; 16'h7005 (STA) after restart pulses reg_we_o with reg_addr_o = 5.
